router_out_scheduler: RTL
=========================

// Module: router_out_scheduler
// PURPOSE
//  Output-side controller of the 1x3 router, clk2 domain (100 kHz). Takes one header per packet
//  (src id, dest id, byte length) plus serial payload bits from the synchronised input side, checks
//  src against trusted sources, maps dest id to output port 1/2/3 and streams payload to that port.
//  Untrusted/malformed packets are consumed and dropped. Honours stop_packet_send backpressure.
// PARAMETERS
//  TS1  8'd1  trusted source id 1
//  TS2  8'd2  trusted source id 2
//  TS3  8'd3  trusted source id 3
// PORTS
//  clk2              in   1  output-domain clock; only clock
//  rst               in   1  asynchronous reset, active-high
//  hdr_valid         in   1  header word available
//  hdr_ready         out  1  header accepted this cycle when hdr_valid&hdr_ready
//  hdr_src           in   8  source id
//  hdr_dest          in   8  destination id
//  hdr_len           in   8  payload length in bytes (bits = hdr_len*8)
//  bit_valid         in   1  payload bit available
//  bit_in            in   1  payload bit, MSB-first
//  bit_ready         out  1  payload bit consumed when bit_valid&bit_ready
//  stop_packet_send  in   1  downstream pause request
//  packet_out1..3    out  1  serial data per port (registered)
//  packet_valid_o1..3 out 1  data-valid per port (registered)
//  fwd_cnt           out  8  packets forwarded, wraps 255->0
//  drop_cnt          out  8  packets dropped, wraps 255->0
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; all packet_out*/packet_valid_o*=0; counters=0; bit counter=0.
//  hdr_ready = (state==IDLE). bit_ready = (state==SEND & !stop_packet_send) | (state==DROP).
//  FSM:
//   IDLE : hdr_valid -> latch src/dest/len -> CHECK.
//   CHECK: one cycle. port = dest 1..85->1, 86..170->2, 171..255->3.
//          trusted = src in {TS1,TS2,TS3}. len==0 -> drop_cnt++, IDLE (no payload consumed).
//          dest==0 or !trusted -> DROP; else SEND. Remaining bits = len*8 (11-bit counter).
//   SEND : each cycle bit_valid&bit_ready: packet_out<port> <= bit_in, packet_valid_o<port> <= 1
//          next cycle (latency 1); counter--. Else packet_valid_o<port> <= 0 (bubble/pause).
//          Last bit consumed -> fwd_cnt++, GAP.
//   DROP : consume bits at full rate ignoring stop_packet_send; no output toggles;
//          last bit -> drop_cnt++, IDLE.
//   GAP  : one cycle, all valids 0 (inter-packet separator) -> IDLE.
//  Non-selected ports: packet_valid_o=0, packet_out holds last value.
//  At most one packet_valid_o* high in any cycle.
//  stop_packet_send rising mid-packet: bit not consumed that cycle, valid drops next cycle, resumes
//  on the same bit order when released; stop in IDLE/CHECK/GAP has no effect.
//  hdr_valid while not IDLE: ignored (hdr_ready=0), header held by source.
//  Max packet 255 bytes = 2040 bits; counter never underflows (exit on count==1 & handshake).
//  Reset mid-packet: partial packet abandoned, counters cleared, no valid glitch after reset.
// STRUCTURE
//  router_pkg: state enum (IDLE,CHECK,SEND,DROP,GAP), port encoding (2'd1..3, 2'd0=none),
//   dest range bounds 8'd85 / 8'd170, length-to-bits shift constant.
//  Sub-module router_dest_decode: combinational dest/src -> {port, trusted}, TS* passed down.
//  Top holds FSM, 11-bit bit counter, output registers, counters.
// TESTING
//  1. src=TS1, dest=8'd10, len=1, 8 bits 10110011, no stop -> port1 emits 10110011 on 8 consecutive
//     valid cycles starting 1 cycle after first bit_ready; fwd_cnt=1; ports 2/3 valid stay 0.
//  2. src=8'd99 (untrusted), dest=8'd200, len=2 -> 16 bits consumed, no valid on any port, drop_cnt=1.
//  3. dest=8'd0 and len=0 headers -> both dropped, len=0 consumes no bits; drop_cnt=2.
//  4. dest=8'd150, len=1, stop_packet_send high for bits 3-5 -> port2 valid low 3 cycles, data order
//     preserved, fwd_cnt=1.
//  5. Boundaries dest=85/86/170/171/255 -> ports 1/2/2/3/3; back-to-back headers show 1-cycle GAP.
//  6. rst asserted during SEND of bit 4 -> all outputs 0 same cycle, next header handled normally.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router output scheduler.
package router_pkg;

  localparam int unsigned ID_W              = 8;
  localparam int unsigned LEN_W             = 8;
  localparam int unsigned CNT_W             = 8;
  localparam int unsigned NUM_PORTS         = 3;
  // Bytes to bits: len * 8.
  localparam int unsigned LEN_TO_BITS_SHIFT = 3;
  // Enough to hold 255 * 8 = 2040 payload bits.
  localparam int unsigned BIT_CNT_W         = LEN_W + LEN_TO_BITS_SHIFT;

  // Upper bounds of the destination id ranges owned by ports 1 and 2.
  localparam logic [ID_W-1:0] DEST_P1_MAX = 8'd85;
  localparam logic [ID_W-1:0] DEST_P2_MAX = 8'd170;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_SEND,
    ST_DROP,
    ST_GAP
  } state_t;

  typedef enum logic [1:0] {
    PORT_NONE = 2'd0,
    PORT_1    = 2'd1,
    PORT_2    = 2'd2,
    PORT_3    = 2'd3
  } port_t;

  typedef struct packed {
    logic [ID_W-1:0]  src;
    logic [ID_W-1:0]  dest;
    logic [LEN_W-1:0] len;
  } hdr_t;

  // Payload length in bytes converted to a bit count.
  function automatic logic [BIT_CNT_W-1:0] len_to_bits(input logic [LEN_W-1:0] len);
    return BIT_CNT_W'(len) << LEN_TO_BITS_SHIFT;
  endfunction

  // One-hot lane select for an output port; PORT_NONE selects nothing.
  function automatic logic [NUM_PORTS-1:0] port_onehot(input port_t port);
    logic [NUM_PORTS-1:0] oh;
    oh = '0;
    case (port)
      PORT_1:  oh = 3'b001;
      PORT_2:  oh = 3'b010;
      PORT_3:  oh = 3'b100;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/router_dest_decode.sv
// Combinational destination-to-port mapping and source trust check.
module router_dest_decode
  import router_pkg::*;
#(
  parameter logic [ID_W-1:0] TS1 = 8'd1,
  parameter logic [ID_W-1:0] TS2 = 8'd2,
  parameter logic [ID_W-1:0] TS3 = 8'd3
) (
  input  logic [ID_W-1:0] dest,
  input  logic [ID_W-1:0] src,
  output port_t           port,
  output logic            trusted
);

  // Range decode of dest id (0 has no port) and trusted-source match.
  always_comb begin
    port    = PORT_NONE;
    trusted = 1'b0;
    if (dest == '0) begin
      port = PORT_NONE;
    end else if (dest <= DEST_P1_MAX) begin
      port = PORT_1;
    end else if (dest <= DEST_P2_MAX) begin
      port = PORT_2;
    end else begin
      port = PORT_3;
    end
    trusted = (src == TS1) || (src == TS2) || (src == TS3);
  end

endmodule

// File: rtl/router_out_scheduler.sv
// Output-side scheduler of the 1x3 router: header check, port select, serial payload forwarding.
module router_out_scheduler
  import router_pkg::*;
#(
  parameter logic [ID_W-1:0] TS1 = 8'd1,
  parameter logic [ID_W-1:0] TS2 = 8'd2,
  parameter logic [ID_W-1:0] TS3 = 8'd3
) (
  input  logic              clk2,
  input  logic              rst,
  input  logic              hdr_valid,
  output logic              hdr_ready,
  input  logic [ID_W-1:0]   hdr_src,
  input  logic [ID_W-1:0]   hdr_dest,
  input  logic [LEN_W-1:0]  hdr_len,
  input  logic              bit_valid,
  input  logic              bit_in,
  output logic              bit_ready,
  input  logic              stop_packet_send,
  output logic              packet_out1,
  output logic              packet_out2,
  output logic              packet_out3,
  output logic              packet_valid_o1,
  output logic              packet_valid_o2,
  output logic              packet_valid_o3,
  output logic [CNT_W-1:0]  fwd_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);

  state_t                 state;
  hdr_t                   hdr_q;
  port_t                  port_q;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic [NUM_PORTS-1:0]   out_q;
  logic [NUM_PORTS-1:0]   vld_q;

  port_t                  dec_port;
  logic                   dec_trusted;
  logic [NUM_PORTS-1:0]   sel_oh;
  logic                   bit_hs;
  logic                   last_bit;

  router_dest_decode #(
    .TS1 (TS1),
    .TS2 (TS2),
    .TS3 (TS3)
  ) u_dest_decode (
    .dest    (hdr_q.dest),
    .src     (hdr_q.src),
    .port    (dec_port),
    .trusted (dec_trusted)
  );

  // Handshake decode from current state; DROP drains regardless of backpressure.
  assign hdr_ready = (state == ST_IDLE);
  assign bit_ready = ((state == ST_SEND) && !stop_packet_send) || (state == ST_DROP);
  assign bit_hs    = bit_valid && bit_ready;
  assign sel_oh    = port_onehot(port_q);
  // Exit on the final handshake so the counter never wraps below zero.
  assign last_bit  = (bit_cnt == BIT_CNT_W'(1));

  assign packet_out1     = out_q[0];
  assign packet_out2     = out_q[1];
  assign packet_out3     = out_q[2];
  assign packet_valid_o1 = vld_q[0];
  assign packet_valid_o2 = vld_q[1];
  assign packet_valid_o3 = vld_q[2];

  // Packet FSM with registered port data/valid and forward/drop counters.
  always_ff @(posedge clk2 or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      hdr_q    <= '0;
      port_q   <= PORT_NONE;
      bit_cnt  <= '0;
      out_q    <= '0;
      vld_q    <= '0;
      fwd_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      // Valids are single-cycle pulses; only a SEND handshake raises one.
      vld_q <= '0;
      case (state)
        ST_IDLE: begin
          if (hdr_valid) begin
            hdr_q <= '{src: hdr_src, dest: hdr_dest, len: hdr_len};
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          port_q  <= dec_port;
          bit_cnt <= len_to_bits(hdr_q.len);
          if (hdr_q.len == '0) begin
            drop_cnt <= drop_cnt + CNT_W'(1);
            state    <= ST_IDLE;
          end else if ((hdr_q.dest == '0) || !dec_trusted) begin
            state <= ST_DROP;
          end else begin
            state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (bit_hs) begin
            // Only the selected lane takes the bit; others hold their last value.
            out_q   <= (out_q & ~sel_oh) | (sel_oh & {NUM_PORTS{bit_in}});
            vld_q   <= sel_oh;
            bit_cnt <= bit_cnt - BIT_CNT_W'(1);
            if (last_bit) begin
              fwd_cnt <= fwd_cnt + CNT_W'(1);
              state   <= ST_GAP;
            end
          end
        end
        ST_DROP: begin
          if (bit_hs) begin
            bit_cnt <= bit_cnt - BIT_CNT_W'(1);
            if (last_bit) begin
              drop_cnt <= drop_cnt + CNT_W'(1);
              state    <= ST_IDLE;
            end
          end
        end
        ST_GAP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
